// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 engine.
//   - game_status encodings (ST_*)
//   - FSM state encoding (state_t), also visible on the core's dbg_state port
//   - scan direction codes used by the line counter (dir_t)
//   - cell_idx(): flat board index, index = row*cols + col, row 0 at the bottom
package connect4_pkg;

    localparam logic [1:0] ST_PLAYING = 2'b00;
    localparam logic [1:0] ST_P1_WIN  = 2'b01;
    localparam logic [1:0] ST_P2_WIN  = 2'b10;
    localparam logic [1:0] ST_DRAW    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIND  = 3'd1,
        S_PLACE = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Horizontal, vertical, rising diagonal (/), falling diagonal (\).
    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D1 = 2'd2,
        DIR_D2 = 2'd3
    } dir_t;

    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/connect4_game_core_line_counter.sv
// c4_line_counter: purely combinational run-length counter.
// Counts the same-owner discs contiguous with the placed cell along one
// direction (both sides, at most WIN_LEN-1 per side) and reports the total
// including the placed cell, saturated at WIN_LEN.
// Ports:
//   board_occ / board_p2  in   board occupancy and ownership maps
//   owner                 in   owner of the placed disc (0 = P1, 1 = P2)
//   row / col             in   coordinates of the placed disc
//   dir                   in   direction being scanned
//   run_len               out  run length, 1..WIN_LEN
module c4_line_counter
    import connect4_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int RUN_W   = 3
) (
    input  logic [ROWS*COLS-1:0] board_occ,
    input  logic [ROWS*COLS-1:0] board_p2,
    input  logic                 owner,
    input  logic [ROW_W-1:0]     row,
    input  logic [COL_W-1:0]     col,
    input  dir_t                 dir,
    output logic [RUN_W-1:0]     run_len
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    int   dr;
    int   dc;
    int   pos_cnt;
    int   neg_cnt;
    int   total;
    logic pos_go;
    logic neg_go;

    // Bounds are checked on (row, col) rather than on the flat index, so a
    // run can never wrap from the end of one row onto the next.
    function automatic logic owned(input logic [CELLS-1:0] occ,
                                   input logic [CELLS-1:0] p2,
                                   input logic who,
                                   input int r,
                                   input int c);
        logic [IDX_W-1:0] idx;
        owned = 1'b0;
        idx   = '0;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            idx   = IDX_W'(cell_idx(r, c, COLS));
            owned = occ[idx] && (p2[idx] == who);
        end
    endfunction

    always_comb begin
        dr = 0;
        dc = 1;
        case (dir)
            DIR_H:   begin dr = 0; dc = 1;  end
            DIR_V:   begin dr = 1; dc = 0;  end
            DIR_D1:  begin dr = 1; dc = 1;  end
            DIR_D2:  begin dr = 1; dc = -1; end
            default: begin dr = 0; dc = 1;  end
        endcase

        pos_cnt = 0;
        neg_cnt = 0;
        pos_go  = 1'b1;
        neg_go  = 1'b1;
        // Each side stops at the first empty/foreign/out-of-board cell.
        for (int k = 1; k < WIN_LEN; k++) begin
            if (pos_go && owned(board_occ, board_p2, owner,
                                int'(row) + k * dr, int'(col) + k * dc))
                pos_cnt = pos_cnt + 1;
            else
                pos_go = 1'b0;
            if (neg_go && owned(board_occ, board_p2, owner,
                                int'(row) - k * dr, int'(col) - k * dc))
                neg_cnt = neg_cnt + 1;
            else
                neg_go = 1'b0;
        end

        total   = 1 + pos_cnt + neg_cnt;
        run_len = (total >= WIN_LEN) ? RUN_W'(WIN_LEN) : RUN_W'(total);
    end

endmodule

// File: rtl/connect4_game_core.sv
// connect4_game_core: Connect-4 engine owning board, turn and game status.
// Ports:
//   clk, reset (async, active low), new_game (sync clear, overrides all)
//   drop_req / drop_col      drop request and target column
//   busy                     high while a drop is being processed
//   drop_ack / drop_err      one-cycle result pulses (never together)
//   cur_player, game_status  turn and result
//   board_occ, board_p2      board maps, index = row*COLS + col
//   led                      registered copy of board_occ[LED_W-1:0]
//   dbg_state                current FSM state (connect4_pkg::state_t)
//
// Request/response protocol: drop_req is a one-cycle pulse accepted only
// while the FSM is IDLE (or OVER, where it is answered with drop_err).
// Every accepted request is answered by exactly one drop_ack or drop_err
// pulse; requests arriving while busy are dropped without any response.
module connect4_game_core
    import connect4_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int COL_W   = 3,
    parameter int LED_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 drop_req,
    input  logic [COL_W-1:0]     drop_col,
    output logic                 busy,
    output logic                 drop_ack,
    output logic                 drop_err,
    output logic                 cur_player,
    output logic [1:0]           game_status,
    output logic [ROWS*COLS-1:0] board_occ,
    output logic [ROWS*COLS-1:0] board_p2,
    output logic [LED_W-1:0]     led,
    output logic [2:0]           dbg_state
);

    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int RUN_W = $clog2(WIN_LEN + 1);

    state_t             state_q,  state_d;
    logic [ROW_W-1:0]   row_q,    row_d;
    logic [COL_W-1:0]   col_q,    col_d;
    dir_t               dir_q,    dir_d;
    logic               win_q,    win_d;
    logic               player_q, player_d;
    logic [1:0]         status_q, status_d;
    logic [CELLS-1:0]   occ_q,    occ_d;
    logic [CELLS-1:0]   p2_q,     p2_d;
    logic [LED_W-1:0]   led_q,    led_d;
    logic               busy_q,   busy_d;
    logic               ack_q,    ack_d;
    logic               err_q,    err_d;

    logic [IDX_W-1:0]   cur_idx;
    logic [RUN_W-1:0]   run_len;
    logic               run_hit;

    assign cur_idx = IDX_W'(cell_idx(int'(row_q), int'(col_q), COLS));

    // Shared by all four CHECK sub-steps; dir_q selects the direction.
    c4_line_counter #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W),
        .RUN_W   (RUN_W)
    ) u_line_counter (
        .board_occ (occ_q),
        .board_p2  (p2_q),
        .owner     (player_q),
        .row       (row_q),
        .col       (col_q),
        .dir       (dir_q),
        .run_len   (run_len)
    );

    assign run_hit = (int'(run_len) >= WIN_LEN);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        win_d    = win_q;
        player_d = player_q;
        status_d = status_q;
        occ_d    = occ_q;
        p2_d     = p2_q;
        led_d    = occ_q[LED_W-1:0];
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (new_game) begin
            state_d  = S_IDLE;
            row_d    = '0;
            col_d    = '0;
            dir_d    = DIR_H;
            win_d    = 1'b0;
            player_d = 1'b0;
            status_d = ST_PLAYING;
            occ_d    = '0;
            p2_d     = '0;
            led_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (drop_req) begin
                        if (int'(drop_col) >= COLS) begin
                            err_d = 1'b1;
                        end else begin
                            col_d   = drop_col;
                            row_d   = '0;
                            state_d = S_FIND;
                        end
                    end
                end
                S_FIND: begin
                    // One row per cycle, bottom up.
                    if (!occ_q[cur_idx]) begin
                        state_d = S_PLACE;
                    end else if (int'(row_q) == ROWS - 1) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
                S_PLACE: begin
                    occ_d[cur_idx] = 1'b1;
                    p2_d[cur_idx]  = player_q;
                    dir_d          = DIR_H;
                    win_d          = 1'b0;
                    state_d        = S_CHECK;
                end
                S_CHECK: begin
                    if (dir_q != DIR_D2) begin
                        win_d = win_q | run_hit;
                        dir_d = dir_t'(dir_q + 2'd1);
                    end else begin
                        ack_d = 1'b1;
                        // Win is decided before draw: a winning last disc
                        // that also fills the board is still a win.
                        if (win_q || run_hit) begin
                            status_d = player_q ? ST_P2_WIN : ST_P1_WIN;
                            state_d  = S_OVER;
                        end else if (&occ_q) begin
                            status_d = ST_DRAW;
                            state_d  = S_OVER;
                        end else begin
                            player_d = ~player_q;
                            state_d  = S_IDLE;
                        end
                    end
                end
                S_OVER: begin
                    if (drop_req)
                        err_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= DIR_H;
            win_q    <= 1'b0;
            player_q <= 1'b0;
            status_q <= ST_PLAYING;
            occ_q    <= '0;
            p2_q     <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            player_q <= player_d;
            status_q <= status_d;
            occ_q    <= occ_d;
            p2_q     <= p2_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign busy        = busy_q;
    assign drop_ack    = ack_q;
    assign drop_err    = err_q;
    assign cur_player  = player_q;
    assign game_status = status_q;
    assign board_occ   = occ_q;
    assign board_p2    = p2_q;
    assign led         = led_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_connect4_game_core.sv
module tb_connect4_game_core;
    import connect4_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- default 6x7 instance ----------------
    logic        new_game, drop_req;
    logic [2:0]  drop_col;
    logic        busy, drop_ack, drop_err, cur_player;
    logic [1:0]  game_status;
    logic [41:0] board_occ, board_p2;
    logic [7:0]  led;
    logic [2:0]  dbg_state;

    connect4_game_core dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .drop_req    (drop_req),
        .drop_col    (drop_col),
        .busy        (busy),
        .drop_ack    (drop_ack),
        .drop_err    (drop_err),
        .cur_player  (cur_player),
        .game_status (game_status),
        .board_occ   (board_occ),
        .board_p2    (board_p2),
        .led         (led),
        .dbg_state   (dbg_state)
    );

    // ---------------- 2x2, WIN_LEN=3 instance ----------------
    logic        s_new_game, s_drop_req;
    logic [0:0]  s_drop_col;
    logic        s_busy, s_drop_ack, s_drop_err, s_cur_player;
    logic [1:0]  s_game_status;
    logic [3:0]  s_board_occ, s_board_p2;
    logic [3:0]  s_led;
    logic [2:0]  s_dbg_state;

    connect4_game_core #(
        .ROWS(2), .COLS(2), .WIN_LEN(3), .COL_W(1), .LED_W(4)
    ) dut_s (
        .clk         (clk),
        .reset       (reset),
        .new_game    (s_new_game),
        .drop_req    (s_drop_req),
        .drop_col    (s_drop_col),
        .busy        (s_busy),
        .drop_ack    (s_drop_ack),
        .drop_err    (s_drop_err),
        .cur_player  (s_cur_player),
        .game_status (s_game_status),
        .board_occ   (s_board_occ),
        .board_p2    (s_board_p2),
        .led         (s_led),
        .dbg_state   (s_dbg_state)
    );

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Pulses drop_req for one cycle and counts rising edges, starting with
    // the sampling edge, until drop_ack or drop_err is seen (bounded).
    task automatic do_drop(input int c, output int n, output logic ack,
                           output logic err, output logic busy_seen);
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = 3'(c);
        @(posedge clk);
        #1;
        drop_req  = 1'b0;
        n         = 1;
        busy_seen = busy;
        ack       = drop_ack;
        err       = drop_err;
        while (!ack && !err && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            busy_seen = busy_seen | busy;
            ack       = drop_ack;
            err       = drop_err;
        end
    endtask

    task automatic drop_expect(input string tag, input int c, input int exp_n, input logic exp_ack);
        int   n;
        logic ack, err, bs;
        do_drop(c, n, ack, err, bs);
        chk({tag, "_lat"}, 64'(n), 64'(exp_n));
        chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
        chk({tag, "_err"}, 64'(err), 64'(!exp_ack));
    endtask

    task automatic s_drop_expect(input string tag, input int c, input int exp_n);
        int   n;
        logic ack, err;
        @(negedge clk);
        s_drop_req = 1'b1;
        s_drop_col = 1'(c);
        @(posedge clk);
        #1;
        s_drop_req = 1'b0;
        n   = 1;
        ack = s_drop_ack;
        err = s_drop_err;
        while (!ack && !err && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            ack = s_drop_ack;
            err = s_drop_err;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_n));
        chk({tag, "_ack"}, 64'(ack), 64'd1);
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n;
        int   acks;
        logic ack, err, bs;

        reset      = 1'b0;
        new_game   = 1'b0;
        drop_req   = 1'b0;
        drop_col   = '0;
        s_new_game = 1'b0;
        s_drop_req = 1'b0;
        s_drop_col = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        chk("rst_occ",    64'(board_occ),   64'd0);
        chk("rst_p2",     64'(board_p2),    64'd0);
        chk("rst_led",    64'(led),         64'd0);
        chk("rst_player", 64'(cur_player),  64'd0);
        chk("rst_status", 64'(game_status), 64'(ST_PLAYING));
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_ack",    64'(drop_ack),    64'd0);
        chk("rst_err",    64'(drop_err),    64'd0);
        chk("rst_state",  64'(dbg_state),   64'(S_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // 1: four drops into column 0
        do_drop(0, n, ack, err, bs);
        chk("t1_d0_lat",  64'(n),  64'd7);
        chk("t1_d0_ack",  64'(ack), 64'd1);
        chk("t1_d0_busy", 64'(bs), 64'd1);
        chk("t1_d0_excl", 64'(ack && err), 64'd0);
        drop_expect("t1_d1", 0, 8, 1'b1);
        drop_expect("t1_d2", 0, 9, 1'b1);
        drop_expect("t1_d3", 0, 10, 1'b1);
        chk("t1_occ",    64'(board_occ),   64'h204081);
        chk("t1_p2",     64'(board_p2),    64'h200080);
        chk("t1_p2_b7",  64'(board_p2[7]), 64'd1);
        chk("t1_player", 64'(cur_player),  64'd0);
        chk("t1_status", 64'(game_status), 64'(ST_PLAYING));
        chk("t1_led",    64'(led),         64'h81);

        // 2: P1 horizontal win on row 0
        start_new_game();
        chk("t2_clear_occ", 64'(board_occ), 64'd0);
        drop_expect("t2_a", 0, 7, 1'b1);
        drop_expect("t2_b", 6, 7, 1'b1);
        drop_expect("t2_c", 1, 7, 1'b1);
        drop_expect("t2_d", 6, 8, 1'b1);
        drop_expect("t2_e", 2, 7, 1'b1);
        drop_expect("t2_f", 6, 9, 1'b1);
        drop_expect("t2_g", 3, 7, 1'b1);
        chk("t2_status", 64'(game_status), 64'(ST_P1_WIN));
        chk("t2_state",  64'(dbg_state),   64'(S_OVER));
        chk("t2_busy",   64'(busy),        64'd0);
        chk("t2_occ",    64'(board_occ),   64'h10204F);
        chk("t2_p2",     64'(board_p2),    64'h102040);
        drop_expect("t2_over", 4, 1, 1'b0);
        chk("t2_over_occ",    64'(board_occ),   64'h10204F);
        chk("t2_over_status", 64'(game_status), 64'(ST_P1_WIN));
        chk("t2_over_player", 64'(cur_player),  64'd0);

        // 3: fill column 2, then overflow it
        start_new_game();
        for (int r = 0; r < 6; r++)
            drop_expect($sformatf("t3_r%0d", r), 2, 7 + r, 1'b1);
        chk("t3_status", 64'(game_status), 64'(ST_PLAYING));
        chk("t3_player", 64'(cur_player),  64'd0);
        drop_expect("t3_full", 2, 7, 1'b0);
        chk("t3_player_after", 64'(cur_player), 64'd0);
        chk("t3_occ",   64'(board_occ), 64'h2040810204);
        chk("t3_p2",    64'(board_p2),  64'h2000800200);
        chk("t3_state", 64'(dbg_state), 64'(S_IDLE));

        // 4a: out-of-range column
        do_drop(7, n, ack, err, bs);
        chk("t4_badcol_lat",  64'(n),   64'd1);
        chk("t4_badcol_err",  64'(err), 64'd1);
        chk("t4_badcol_ack",  64'(ack), 64'd0);
        chk("t4_badcol_busy", 64'(bs),  64'd0);
        chk("t4_badcol_occ",  64'(board_occ), 64'h2040810204);

        // 4b: 2x2 board, WIN_LEN=3, fill to a draw
        s_drop_expect("t4s_a", 0, 7);
        s_drop_expect("t4s_b", 1, 7);
        s_drop_expect("t4s_c", 0, 8);
        s_drop_expect("t4s_d", 1, 8);
        chk("t4s_status", 64'(s_game_status), 64'(ST_DRAW));
        chk("t4s_state",  64'(s_dbg_state),   64'(S_OVER));
        chk("t4s_occ",    64'(s_board_occ),   64'hF);
        chk("t4s_p2",     64'(s_board_p2),    64'hA);
        chk("t4s_led",    64'(s_led),         64'hF);
        chk("t4s_player", 64'(s_cur_player),  64'd1);

        // 5a: P2 rising diagonal (0,0)..(3,3)
        start_new_game();
        drop_expect("t5_1", 1, 7, 1'b1);
        drop_expect("t5_2", 0, 7, 1'b1);
        drop_expect("t5_3", 2, 7, 1'b1);
        drop_expect("t5_4", 1, 8, 1'b1);
        drop_expect("t5_5", 3, 7, 1'b1);
        drop_expect("t5_6", 2, 8, 1'b1);
        drop_expect("t5_7", 3, 8, 1'b1);
        drop_expect("t5_8", 2, 9, 1'b1);
        drop_expect("t5_9", 3, 9, 1'b1);
        chk("t5_pre_status", 64'(game_status), 64'(ST_PLAYING));
        drop_expect("t5_10", 3, 10, 1'b1);
        chk("t5_status", 64'(game_status), 64'(ST_P2_WIN));
        chk("t5_occ",    64'(board_occ),   64'h103070F);
        chk("t5_p2",     64'(board_p2),    64'h1010301);
        chk("t5_player", 64'(cur_player),  64'd1);

        // 5b: P1 on cells 5,6,7,8 (crosses a row edge) is not a win
        start_new_game();
        drop_expect("t5b_1", 5, 7, 1'b1);
        drop_expect("t5b_2", 0, 7, 1'b1);
        drop_expect("t5b_3", 6, 7, 1'b1);
        drop_expect("t5b_4", 1, 7, 1'b1);
        drop_expect("t5b_5", 0, 8, 1'b1);
        drop_expect("t5b_6", 4, 7, 1'b1);
        drop_expect("t5b_7", 1, 8, 1'b1);
        chk("t5b_status", 64'(game_status), 64'(ST_PLAYING));
        chk("t5b_occ",    64'(board_occ),   64'h1F3);
        chk("t5b_p2",     64'(board_p2),    64'h13);
        chk("t5b_led",    64'(led),         64'hF3);
        chk("t5b_player", 64'(cur_player),  64'd1);

        // 6a: asynchronous reset while in CHECK
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = 3'd3;
        @(posedge clk);
        #1;
        drop_req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("t6_in_check", 64'(dbg_state), 64'(S_CHECK));
        reset = 1'b0;
        #1;
        chk("t6_occ",    64'(board_occ),   64'd0);
        chk("t6_p2",     64'(board_p2),    64'd0);
        chk("t6_led",    64'(led),         64'd0);
        chk("t6_player", 64'(cur_player),  64'd0);
        chk("t6_status", 64'(game_status), 64'(ST_PLAYING));
        chk("t6_busy",   64'(busy),        64'd0);
        chk("t6_ack",    64'(drop_ack),    64'd0);
        chk("t6_state",  64'(dbg_state),   64'(S_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // 6b: new_game while in FIND
        drop_expect("t6b_first", 0, 7, 1'b1);
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = 3'd0;
        @(posedge clk);
        #1;
        drop_req = 1'b0;
        chk("t6b_in_find", 64'(dbg_state), 64'(S_FIND));
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        chk("t6b_occ",    64'(board_occ),  64'd0);
        chk("t6b_state",  64'(dbg_state),  64'(S_IDLE));
        chk("t6b_busy",   64'(busy),       64'd0);
        chk("t6b_player", 64'(cur_player), 64'd0);
        @(negedge clk);
        new_game = 1'b0;
        acks = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (drop_ack) acks++;
        end
        chk("t6b_no_ack", 64'(acks), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
